// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift/rotate sequencer: default widths,
// operation encodings and FSM state type.
package shift_seq_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int CNT_W_DEFAULT = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_step.sv
// Single 1-bit shift/rotate stage; the sequencer applies it once per clock.
module shift_step
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (op)
      OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
      OP_ROR:  q = {d[0], d[WIDTH-1:1]};
      OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Start/busy/done sequencer performing a multi-bit rotate or shift as a
// series of 1-bit steps, one per clock.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step_data;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d  (data_q),
    .op (op_q),
    .q  (step_data)
  );

  // out is loaded on entry to DONE so it already holds the result while done is high.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d = in;
          op_d   = op;
          rem_d  = cnt;
          if (cnt == '0) begin
            state_d = ST_DONE;
            out_d   = in;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        data_d = step_data;
        rem_d  = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          out_d   = step_data;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: a cycle-level reference model plus
// directed operations with literal expected results and latencies.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic [1:0]  op_i = 2'b00;
  logic [15:0] in_i = 16'h5A5A;
  logic [3:0]  cnt_i = 4'd3;
  logic        busy;
  logic        done;
  logic [15:0] dut_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  int          m_left = 0;
  logic [15:0] m_res  = 16'h0000;
  logic [15:0] m_out  = 16'h0000;

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op_i),
    .in    (in_i),
    .cnt   (cnt_i),
    .busy  (busy),
    .done  (done),
    .out   (dut_out)
  );

  always #5 clk = ~clk;

  // Whole-operation result from plain shift arithmetic on a widened operand.
  function automatic logic [15:0] refOp(input logic [1:0] o, input logic [15:0] x,
                                        input logic [3:0] n);
    logic [31:0] xx;
    logic [31:0] r;
    int s;
    xx = {16'h0000, x};
    s  = int'(n);
    case (o)
      2'b00:   r = (xx << s) | (xx >> (16 - s));
      2'b01:   r = xx << s;
      2'b10:   r = (xx >> s) | (xx << (16 - s));
      default: r = xx >> s;
    endcase
    return r[15:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request keeps the unit busy for cnt+1 cycles, the last
  // of which is the done cycle, and the result appears at the start of that cycle.
  always @(posedge clk) begin : model
    automatic int          left = m_left;
    automatic logic [15:0] res  = m_res;
    automatic logic [15:0] o    = m_out;
    if (rst) begin
      left = 0;
      o    = 16'h0000;
    end else begin
      if (left > 0) left--;
      else if (start) begin
        left = int'(cnt_i) + 1;
        res  = refOp(op_i, in_i, cnt_i);
      end
      if (left == 1) o = res;
    end
    m_left <= left;
    m_res  <= res;
    m_out  <= o;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      checkOutput("model_done", {31'd0, done}, {31'd0, (m_left == 1)});
      checkOutput("model_out", {16'd0, dut_out}, {16'd0, m_out});
    end
  end

  task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [15:0] x,
                               input logic [3:0] n);
    start = s;
    op_i  = o;
    in_i  = x;
    cnt_i = n;
  endtask

  // Issue one request, wait (bounded) for done, check latency and result,
  // then leave one idle cycle before returning.
  task automatic runOp(input string name, input logic [1:0] o, input logic [15:0] x,
                       input logic [3:0] n, input logic [15:0] exp_out, input int exp_lat);
    int k;
    logic found;
    found = 1'b0;
    k = 0;
    @(negedge clk);
    applyStimulus(1'b1, o, x, n);
    while (!found && k < 40) begin
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 16'h0000, 4'd0);
      k++;
      if (done) found = 1'b1;
    end
    checkOutput({name, "_seen"}, {31'd0, found}, 32'd1);
    checkOutput({name, "_lat"}, k, exp_lat);
    checkOutput({name, "_out"}, {16'd0, dut_out}, {16'd0, exp_out});
    @(negedge clk);
    checkOutput({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    int done_cyc;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_out", {16'd0, dut_out}, 32'h0000);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 16'h0000, 4'd0);
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_accept", {31'd0, busy}, 32'd0);

    runOp("rol1",  2'b00, 16'h8001, 4'd1,  16'h0003, 2);
    runOp("ror4",  2'b10, 16'h1234, 4'd4,  16'h4123, 5);
    runOp("sll15", 2'b01, 16'hFFFF, 4'd15, 16'h8000, 16);
    runOp("srl0",  2'b11, 16'hABCD, 4'd0,  16'hABCD, 1);
    runOp("srl3",  2'b11, 16'h8000, 4'd3,  16'h1000, 4);
    runOp("ror15", 2'b10, 16'h0001, 4'd15, 16'h0002, 16);

    // Busy collision: extra start pulses during RUN and during DONE are dropped.
    n_done = 0;
    done_cyc = -1;
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 16'h00FF, 4'd8);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      applyStimulus((c == 3 || c == 9), 2'b01, 16'h0000, 4'd2);
      if (c == 1) checkOutput("coll_busy_c1", {31'd0, busy}, 32'd1);
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (c == 9) checkOutput("coll_out", {16'd0, dut_out}, 32'hFF00);
      if (c == 10) checkOutput("coll_busy_c10", {31'd0, busy}, 32'd0);
    end
    checkOutput("coll_done_count", n_done, 1);
    checkOutput("coll_done_cycle", done_cyc, 9);

    // Reset mid-operation, then a fresh SRL request from cycle 7.
    n_done = 0;
    done_cyc = -1;
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 16'h1234, 4'd10);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      rst = (c == 5);
      if (c == 7) applyStimulus(1'b1, 2'b11, 16'h8000, 4'd3);
      else applyStimulus(1'b0, 2'b00, 16'h0000, 4'd0);
      if (c == 6) begin
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_out", {16'd0, dut_out}, 32'h0000);
      end
      if (done) begin
        n_done++;
        done_cyc = c;
      end
    end
    checkOutput("abort_done_count", n_done, 1);
    checkOutput("abort_done_cycle", done_cyc, 11);
    checkOutput("abort_new_out", {16'd0, dut_out}, 32'h1000);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
